// File: rtl/gate_sweep_ctrl.sv
// rtl/gate_sweep_ctrl.sv - sweeps a 2-input gate through its four input vectors and checks the captured truth table
module gate_sweep_ctrl #(
    parameter int         HOLD_CYCLES = 2,
    parameter logic [3:0] EXP_TABLE   = 4'b0110
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic       abort_i,
    input  logic       F_i,
    output logic       A_o,
    output logic       B_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       pass_o,
    output logic [3:0] result_o,
    output logic [3:0] fail_mask_o
);

    localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             a_d, b_d, busy_d, done_d, pass_d;
    logic [3:0]       result_d, mask_d;
    logic [3:0]       captured;

    // Table as it stands once the current vector's F_i is folded in.
    always_comb begin
        captured        = result_o;
        captured[idx_q] = F_i;
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        a_d      = 1'b0;
        b_d      = 1'b0;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        pass_d   = pass_o;
        result_d = result_o;
        mask_d   = fail_mask_o;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d  = RUN;
                    idx_d    = 2'd0;
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                    result_d = 4'b0000;
                    pass_d   = 1'b0;
                    mask_d   = 4'b0000;
                end
            end
            RUN: begin
                if (abort_i) begin
                    state_d = IDLE;
                    pass_d  = 1'b0;
                    mask_d  = 4'b0000;
                end else if (cnt_q == CNT_LAST) begin
                    result_d = captured;
                    if (idx_q != 2'd3) begin
                        idx_d        = idx_q + 2'd1;
                        cnt_d        = '0;
                        busy_d       = 1'b1;
                        {b_d, a_d}   = idx_q + 2'd1;
                    end else begin
                        state_d = DONE;
                        pass_d  = (captured == EXP_TABLE);
                        mask_d  = captured ^ EXP_TABLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    cnt_d      = cnt_q + CNT_W'(1);
                    busy_d     = 1'b1;
                    {b_d, a_d} = idx_q;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            idx_q       <= 2'd0;
            cnt_q       <= '0;
            A_o         <= 1'b0;
            B_o         <= 1'b0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            pass_o      <= 1'b0;
            result_o    <= 4'b0000;
            fail_mask_o <= 4'b0000;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            A_o         <= a_d;
            B_o         <= b_d;
            busy_o      <= busy_d;
            done_o      <= done_d;
            pass_o      <= pass_d;
            result_o    <= result_d;
            fail_mask_o <= mask_d;
        end
    end

endmodule
